// File: rtl/modred_sched.sv
// Round-robin front end that shares one serial shift-add modular reducer among
// NUM_REQ requesters, with a modulus config register and a reducer watchdog.
module modred_sched #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 64,
    parameter int TIMEOUT = 256
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       cfg_we_i,
    input  logic [WIDTH-1:0]           cfg_m_i,
    output logic                       cfg_ready_o,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*WIDTH-1:0]   req_x_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic                       red_start_o,
    output logic [WIDTH-1:0]           red_x_o,
    output logic [WIDTH-1:0]           red_m_o,
    output logic [WIDTH-1:0]           red_m_bl_o,
    input  logic [WIDTH-1:0]           red_result_i,
    input  logic                       red_valid_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [WIDTH-1:0]           rsp_data_o,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id_o,
    output logic                       rsp_err_o
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   last_q, last_d, id_q, id_d;
    logic [WIDTH-1:0] m_q, m_d, mbl_q, mbl_d, x_q, x_d, data_q, data_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;

    logic             found;
    logic [IDW-1:0]   gidx, cand;
    logic [WIDTH-1:0] m_eff;

    // ceil(log2(m)) is the bit length of m-1; m==0 maps to 0.
    function automatic logic [WIDTH-1:0] ceil_log2(input logic [WIDTH-1:0] m);
        logic [WIDTH-1:0] v;
        ceil_log2 = '0;
        v = m - WIDTH'(1);
        if (m != '0)
            for (int b = 0; b < WIDTH; b++)
                if (v[b]) ceil_log2 = WIDTH'(b + 1);
    endfunction

    always_comb begin
        found = 1'b0;
        gidx  = '0;
        cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDW'((int'(last_q) + i) % NUM_REQ);
            if (!found && req_valid_i[cand]) begin
                found = 1'b1;
                gidx  = cand;
            end
        end
    end

    // A config write accepted alongside a grant already governs that request.
    assign m_eff = (cfg_we_i && state_q == S_IDLE) ? cfg_m_i : m_q;

    always_comb begin
        req_ready_o = '0;
        if (state_q == S_IDLE && found) req_ready_o[gidx] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        m_d     = m_q;
        mbl_d   = mbl_q;
        x_d     = x_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (cfg_we_i) begin
                    m_d   = cfg_m_i;
                    mbl_d = ceil_log2(cfg_m_i);
                end
                if (found) begin
                    last_d = gidx;
                    id_d   = gidx;
                    x_d    = req_x_i[gidx*WIDTH +: WIDTH];
                    if (m_eff == '0) begin
                        data_d  = '0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (red_valid_i) begin
                    data_d  = red_result_i;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            last_q  <= IDW'(NUM_REQ - 1);
            id_q    <= '0;
            m_q     <= '0;
            mbl_q   <= '0;
            x_q     <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            m_q     <= m_d;
            mbl_q   <= mbl_d;
            x_q     <= x_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign cfg_ready_o = (state_q == S_IDLE);
    assign red_start_o = (state_q == S_ISSUE);
    assign red_x_o     = x_q;
    assign red_m_o     = m_q;
    assign red_m_bl_o  = mbl_q;
    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_data_o  = data_q;
    assign rsp_id_o    = id_q;
    assign rsp_err_o   = err_q;
endmodule
